// File: rtl/router_input_fifo_if.sv
// Flit handshake and crossbar-side bundle for one router input port.
`timescale 1ns/1ps
interface router_input_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  DRTS;
    logic [DATA_WIDTH-1:0] RX;
    logic                  CTS;
    logic                  read_en_N;
    logic                  read_en_E;
    logic                  read_en_W;
    logic                  read_en_S;
    logic                  read_en_L;
    logic [DATA_WIDTH-1:0] Data_out;
    logic                  empty;
    logic                  full;

    // Upstream sender plus downstream arbiters/routing, seen as one peer.
    modport master (
        output DRTS, RX, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        input  CTS, Data_out, empty, full
    );

    modport slave (
        input  DRTS, RX, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        output CTS, Data_out, empty, full
    );
endinterface

// File: rtl/router_input_fifo.sv
// NoC router input buffer: RTS/CTS write side, one-hot pointer FIFO, pop on any arbiter grant.
// Optional sticky grant-error flag enabled by defining ROUTER_FIFO_ERR_EN.
`timescale 1ns/1ps
module router_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst,
    router_input_fifo_if.slave bus
`ifdef ROUTER_FIFO_ERR_EN
    ,
    output logic               err
`endif
);
    localparam int               CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  cts_q, cts_d;
    logic                  empty, full;
    logic                  any_ren;
    logic                  wr, rd;
    logic [DATA_WIDTH-1:0] head;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign any_ren = bus.read_en_N | bus.read_en_E | bus.read_en_W
                   | bus.read_en_S | bus.read_en_L;

    // A DRTS still high while CTS is up is the tail of the previous flit.
    assign cts_d = bus.DRTS & ~cts_q & ~full;
    assign wr    = cts_d;
    assign rd    = any_ren & ~empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (rd) rd_ptr_d = {rd_ptr_q[DEPTH-2:0], rd_ptr_q[DEPTH-1]};
        if (wr) wr_ptr_d = {wr_ptr_q[DEPTH-2:0], wr_ptr_q[DEPTH-1]};
        if (wr && !rd)      cnt_d = cnt_q + 1'b1;
        else if (rd && !wr) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= DEPTH'(1);
            wr_ptr_q <= DEPTH'(1);
            cnt_q    <= '0;
            cts_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            cts_q    <= cts_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst && wr && wr_ptr_q[i]) mem_q[i] <= bus.RX;
        end
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr_q[i]) head = head | mem_q[i];
        end
    end

    assign bus.CTS      = cts_q;
    assign bus.Data_out = head;
    assign bus.empty    = empty;
    assign bus.full     = full;

`ifdef ROUTER_FIFO_ERR_EN
    logic       err_q, err_d;
    logic [2:0] n_ren;

    assign n_ren = {2'b00, bus.read_en_N} + {2'b00, bus.read_en_E}
                 + {2'b00, bus.read_en_W} + {2'b00, bus.read_en_S}
                 + {2'b00, bus.read_en_L};

    // Grant on an empty port or multiple simultaneous grants means an arbiter fault.
    assign err_d = err_q | (any_ren & empty) | (n_ren > 3'd1);

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`endif
endmodule

// File: tb/tb_router_input_fifo.sv
// Scoreboard bench for router_input_fifo: flits queued on issue, checked as they are popped.
`timescale 1ns/1ps
module tb_router_input_fifo;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_input_fifo_if #(.DATA_WIDTH(32)) bus ();
`ifdef ROUTER_FIFO_ERR_EN
    logic err;
`endif

    router_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef ROUTER_FIFO_ERR_EN
        ,
        .err (err)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ren(input int which, input logic v);
        case (which)
            0: bus.read_en_N = v;
            1: bus.read_en_E = v;
            2: bus.read_en_W = v;
            3: bus.read_en_S = v;
            default: bus.read_en_L = v;
        endcase
    endtask

    // Returns on the cycle CTS is seen high, with DRTS already dropped.
    task automatic send(input logic [31:0] d);
        int n;
        bus.DRTS = 1'b1;
        bus.RX   = d;
        expq.push_back(d);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.CTS && n < 20);
        if (!bus.CTS) chk("send_cts_timeout", {31'd0, bus.CTS}, 32'd1);
        bus.DRTS = 1'b0;
    endtask

    task automatic pop(input int which);
        set_ren(which, 1'b1);
        tick();
        set_ren(which, 1'b0);
    endtask

    // Monitor: every effective pop must present the oldest outstanding flit.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !bus.empty &&
                (bus.read_en_N | bus.read_en_E | bus.read_en_W | bus.read_en_S | bus.read_en_L)) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got %0h expected none", bus.Data_out);
                end else begin
                    chk("pop_data", bus.Data_out, expq.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.DRTS = 1'b0;
        bus.RX = '0;
        bus.read_en_N = 1'b0;
        bus.read_en_E = 1'b0;
        bus.read_en_W = 1'b0;
        bus.read_en_S = 1'b0;
        bus.read_en_L = 1'b0;
        tick();
        tick();
        chk("rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("rst_full", {31'd0, bus.full}, 32'd0);
        chk("rst_cts", {31'd0, bus.CTS}, 32'd0);
        chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
`ifdef ROUTER_FIFO_ERR_EN
        chk("rst_err", {31'd0, err}, 32'd0);
`endif
        rst = 1'b0;

        // First flit; DRTS held one cycle past CTS must not be a second write.
        bus.DRTS = 1'b1;
        bus.RX   = 32'hA5A5_0001;
        expq.push_back(32'hA5A5_0001);
        tick();
        chk("s1_cts", {31'd0, bus.CTS}, 32'd1);
        chk("s1_empty", {31'd0, bus.empty}, 32'd0);
        chk("s1_head", bus.Data_out, 32'hA5A5_0001);
        chk("s1_cnt", 32'(dut.cnt_q), 32'd1);
        tick();
        chk("s1_cts_drop", {31'd0, bus.CTS}, 32'd0);
        chk("s1_no_dup", 32'(dut.cnt_q), 32'd1);
        bus.DRTS = 1'b0;
        pop(0);
        chk("s1_empty_after", {31'd0, bus.empty}, 32'd1);

        // Fill to full; 5th flit waits for a pop.
        for (int i = 1; i <= 4; i++) send(32'(i));
        chk("s2_full", {31'd0, bus.full}, 32'd1);
        chk("s2_cnt", 32'(dut.cnt_q), 32'd4);
        bus.DRTS = 1'b1;
        bus.RX   = 32'h5;
        expq.push_back(32'h5);
        tick();
        tick();
        tick();
        chk("s2_blocked", {31'd0, bus.CTS}, 32'd0);
        bus.read_en_E = 1'b1;
        tick();
        bus.read_en_E = 1'b0;
        chk("s2_pop_no_cts", {31'd0, bus.CTS}, 32'd0);
        chk("s2_cnt_pop", 32'(dut.cnt_q), 32'd3);
        tick();
        chk("s2_cts_after_pop", {31'd0, bus.CTS}, 32'd1);
        chk("s2_refull", 32'(dut.cnt_q), 32'd4);
        bus.DRTS = 1'b0;
        for (int i = 0; i < 4; i++) pop(i);
        chk("s2_empty", {31'd0, bus.empty}, 32'd1);

        // Simultaneous write and read at occupancy 2.
        send(32'h11);
        send(32'h12);
        tick();
        bus.DRTS = 1'b1;
        bus.RX   = 32'h13;
        expq.push_back(32'h13);
        bus.read_en_L = 1'b1;
        tick();
        bus.read_en_L = 1'b0;
        bus.DRTS = 1'b0;
        chk("s3_cts", {31'd0, bus.CTS}, 32'd1);
        chk("s3_cnt", 32'(dut.cnt_q), 32'd2);
        chk("s3_head", bus.Data_out, 32'h12);
        pop(4);
        pop(2);
        chk("s3_empty", {31'd0, bus.empty}, 32'd1);

        // Fill, drain, refill, drain across pointer wrap.
        for (int i = 1; i <= 4; i++) send(32'(i));
        chk("s4_full1", {31'd0, bus.full}, 32'd1);
        for (int i = 0; i < 4; i++) pop(i);
        chk("s4_empty1", {31'd0, bus.empty}, 32'd1);
        for (int i = 5; i <= 8; i++) send(32'(i));
        chk("s4_full2", {31'd0, bus.full}, 32'd1);
        chk("s4_head2", bus.Data_out, 32'h5);
        for (int i = 4; i >= 1; i--) pop(i);
        chk("s4_empty2", {31'd0, bus.empty}, 32'd1);

        // Pop on empty, then a double grant.
        tick();
        bus.read_en_N = 1'b1;
        tick();
        bus.read_en_N = 1'b0;
        chk("s5_cnt", 32'(dut.cnt_q), 32'd0);
        chk("s5_empty", {31'd0, bus.empty}, 32'd1);
`ifdef ROUTER_FIFO_ERR_EN
        chk("s5_err_set", {31'd0, err}, 32'd1);
        tick();
        chk("s5_err_hold", {31'd0, err}, 32'd1);
`endif
        send(32'h31);
        send(32'h32);
        chk("s5_head", bus.Data_out, 32'h31);
        tick();
        bus.read_en_N = 1'b1;
        bus.read_en_S = 1'b1;
        tick();
        bus.read_en_N = 1'b0;
        bus.read_en_S = 1'b0;
        chk("s5_dual_cnt", 32'(dut.cnt_q), 32'd1);
        chk("s5_dual_head", bus.Data_out, 32'h32);
        pop(1);

        // Reset while a flit is in flight with 3 stored.
        send(32'h21);
        send(32'h22);
        send(32'h23);
        tick();
        bus.DRTS = 1'b1;
        bus.RX   = 32'h24;
        tick();
        rst = 1'b1;
        tick();
        expq.delete();
        chk("s6_empty", {31'd0, bus.empty}, 32'd1);
        chk("s6_cts", {31'd0, bus.CTS}, 32'd0);
        chk("s6_cnt", 32'(dut.cnt_q), 32'd0);
        chk("s6_full", {31'd0, bus.full}, 32'd0);
`ifdef ROUTER_FIFO_ERR_EN
        chk("s6_err_clr", {31'd0, err}, 32'd0);
`endif
        bus.DRTS = 1'b0;
        rst = 1'b0;
        tick();
        send(32'h41);
        chk("s6_head", bus.Data_out, 32'h41);
        pop(3);
        chk("s6_final_empty", {31'd0, bus.empty}, 32'd1);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
